// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the alu_sched block: FSM states, ALU mode bits and select codes.
package alu_sched_pkg;

   localparam int DATA_W = 16;
   localparam int SEL_W  = 4;

   localparam logic MODE_ARITH = 1'b0;
   localparam logic MODE_LOGIC = 1'b1;

   // Arithmetic and logic codes overlap; the mode bit tells them apart
   localparam logic [SEL_W-1:0] SEL_ADD = 4'b1001;
   localparam logic [SEL_W-1:0] SEL_SUB = 4'b0110;
   localparam logic [SEL_W-1:0] SEL_XOR = 4'b0110;
   localparam logic [SEL_W-1:0] SEL_AND = 4'b1011;
   localparam logic [SEL_W-1:0] SEL_OR  = 4'b1110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_sched_if.sv
// Bundles the requester, ALU-drive and response signals of alu_sched; slave is the scheduler side.
interface alu_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   import alu_sched_pkg::*;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [DATA_W*NUM_REQ-1:0] req_a;
   logic [DATA_W*NUM_REQ-1:0] req_b;
   logic [SEL_W*NUM_REQ-1:0]  req_select;
   logic [NUM_REQ-1:0]        req_mode;
   logic [NUM_REQ-1:0]        req_carry;
   logic [NUM_REQ-1:0]        req_use_flag;

   logic [DATA_W-1:0]         alu_in_a;
   logic [DATA_W-1:0]         alu_in_b;
   logic [SEL_W-1:0]          alu_select;
   logic                      alu_mode;
   logic                      alu_carry_in;
   logic [DATA_W-1:0]         alu_out;
   logic                      alu_carry_out;
   logic                      alu_compare;

   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [ID_W-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_data;
   logic                      rsp_carry;
   logic                      rsp_compare;

   modport slave (
      input  req_valid, req_a, req_b, req_select, req_mode, req_carry, req_use_flag,
      input  alu_out, alu_carry_out, alu_compare, rsp_ready,
      output req_ready, alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
      output rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_compare
   );

   modport master (
      output req_valid, req_a, req_b, req_select, req_mode, req_carry, req_use_flag,
      output alu_out, alu_carry_out, alu_compare, rsp_ready,
      input  req_ready, alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
      input  rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_compare
   );

endinterface

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request strictly after i_ptr, wrapping to 0.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any
);

   // Two ordered sweeps: indices above the pointer first, then the wrapped-around ones
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int c = 0; c < NUM_REQ; c++) begin
         if (!o_any && (c > int'(i_ptr)) && i_req[c]) begin
            o_any      = 1'b1;
            o_grant[c] = 1'b1;
            o_idx      = ID_W'(c);
         end
      end
      for (int c = 0; c < NUM_REQ; c++) begin
         if (!o_any && (c <= int'(i_ptr)) && i_req[c]) begin
            o_any      = 1'b1;
            o_grant[c] = 1'b1;
            o_idx      = ID_W'(c);
         end
      end
   end

endmodule

// File: rtl/alu_sched.sv
// Shares one combinational ALU among NUM_REQ requesters, one operation in flight (IDLE/EXEC/RESP).
// Optional per-requester carry chaining is enabled by defining ALU_SCHED_CARRY_CHAIN_EN.
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input logic       clk,
   input logic       rst_n,
   alu_sched_if.slave bus
);

   state_e              r_state;
   state_e              w_nextState;
   logic [ID_W-1:0]     r_ptr;
   logic [ID_W-1:0]     r_id;
   logic [NUM_REQ-1:0]  w_grant;
   logic [ID_W-1:0]     w_grantIdx;
   logic                w_grantAny;
   logic                w_accept;
   logic                w_carrySel;
   logic [NUM_REQ-1:0]  w_reqReady;
   logic                w_rspValid;

   logic [DATA_W-1:0]   r_aluA;
   logic [DATA_W-1:0]   r_aluB;
   logic [SEL_W-1:0]    r_aluSel;
   logic                r_aluMode;
   logic                r_aluCarry;

   logic [ID_W-1:0]     r_rspId;
   logic [DATA_W-1:0]   r_rspData;
   logic                r_rspCarry;
   logic                r_rspCompare;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .i_req   (bus.req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_grantIdx),
      .o_any   (w_grantAny)
   );

   assign w_accept = (r_state == IDLE) && w_grantAny;

`ifdef ALU_SCHED_CARRY_CHAIN_EN
   logic [NUM_REQ-1:0] r_flag;

   assign w_carrySel = bus.req_use_flag[w_grantIdx] ? r_flag[w_grantIdx]
                                                    : bus.req_carry[w_grantIdx];

   // Only arithmetic results feed the chain; logic ops leave the saved carry untouched
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_flag <= '0;
      end else if ((r_state == EXEC) && (r_aluMode == MODE_ARITH)) begin
         r_flag[r_id] <= bus.alu_carry_out;
      end
   end
`else
   logic w_unusedUseFlag;
   assign w_unusedUseFlag = ^bus.req_use_flag;
   assign w_carrySel      = bus.req_carry[w_grantIdx];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = EXEC;
         EXEC:    w_nextState = RESP;
         RESP:    if (bus.rsp_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Ready is masked during reset so nothing appears accepted while the block is held
   always_comb begin
      w_reqReady = '0;
      w_rspValid = 1'b0;
      case (r_state)
         IDLE:    w_reqReady = rst_n ? w_grant : '0;
         RESP:    w_rspValid = 1'b1;
         default: ;
      endcase
   end

   // ALU-drive registers double as the operand latch, so the ALU inputs stay quiet outside EXEC
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr        <= ID_W'(NUM_REQ - 1);
         r_id         <= '0;
         r_aluA       <= '0;
         r_aluB       <= '0;
         r_aluSel     <= '0;
         r_aluMode    <= 1'b0;
         r_aluCarry   <= 1'b0;
         r_rspId      <= '0;
         r_rspData    <= '0;
         r_rspCarry   <= 1'b0;
         r_rspCompare <= 1'b0;
      end else begin
         if (w_accept) begin
            r_ptr      <= w_grantIdx;
            r_id       <= w_grantIdx;
            r_aluA     <= bus.req_a[DATA_W*w_grantIdx +: DATA_W];
            r_aluB     <= bus.req_b[DATA_W*w_grantIdx +: DATA_W];
            r_aluSel   <= bus.req_select[SEL_W*w_grantIdx +: SEL_W];
            r_aluMode  <= bus.req_mode[w_grantIdx];
            r_aluCarry <= w_carrySel;
         end
         if (r_state == EXEC) begin
            r_rspId      <= r_id;
            r_rspData    <= bus.alu_out;
            r_rspCarry   <= bus.alu_carry_out;
            r_rspCompare <= bus.alu_compare;
         end
      end
   end

   assign bus.req_ready    = w_reqReady;
   assign bus.alu_in_a     = r_aluA;
   assign bus.alu_in_b     = r_aluB;
   assign bus.alu_select   = r_aluSel;
   assign bus.alu_mode     = r_aluMode;
   assign bus.alu_carry_in = r_aluCarry;
   assign bus.rsp_valid    = w_rspValid;
   assign bus.rsp_id       = r_rspId;
   assign bus.rsp_data     = r_rspData;
   assign bus.rsp_carry    = r_rspCarry;
   assign bus.rsp_compare  = r_rspCompare;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: behavioural ALU, directed vector table, multi-cycle corner sequences, random traffic.
`timescale 1ns/1ps
module tb_alu_sched;
   import alu_sched_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

   alu_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [15:0] data;
      logic        carry;
      logic        compare;
   } aluRes_t;

   typedef struct {
      int          idx;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  sel;
      logic        mode;
      logic        cin;
      logic [15:0] expData;
      logic        expCarry;
      logic        expCompare;
   } vec_t;

   int testsRun  = 0;
   int failCount = 0;

   logic [15:0]        opA   [NUM_REQ];
   logic [15:0]        opB   [NUM_REQ];
   logic [3:0]         opSel [NUM_REQ];
   logic               opMode[NUM_REQ];
   logic               opCin [NUM_REQ];
   logic               opUse [NUM_REQ];
   int                 lastGrant;
   logic [NUM_REQ-1:0] flagModel;

   // ALU behaviour in the same select/mode encoding the scheduler is paired with
   function automatic aluRes_t aluModel(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] sel, input logic mode, input logic cin);
      aluRes_t     r;
      logic [16:0] s;
      r.compare = (a == b);
      r.carry   = 1'b0;
      r.data    = a;
      s         = '0;
      if (mode == MODE_ARITH) begin
         case (sel)
            SEL_ADD: s = {1'b0, a} + {1'b0, b} + 17'(cin);
            SEL_SUB: s = {1'b0, a} + {1'b0, ~b} + 17'(cin);
            default: s = {1'b0, a} + 17'(cin);
         endcase
         r.data  = s[15:0];
         r.carry = s[16];
      end else begin
         case (sel)
            SEL_XOR: r.data = a ^ b;
            SEL_AND: r.data = a & b;
            SEL_OR:  r.data = a | b;
            4'b0000: r.data = ~a;
            default: r.data = a;
         endcase
      end
      return r;
   endfunction

   aluRes_t aluNow;
   assign aluNow            = aluModel(bus.alu_in_a, bus.alu_in_b, bus.alu_select,
                                       bus.alu_mode, bus.alu_carry_in);
   assign bus.alu_out       = aluNow.data;
   assign bus.alu_carry_out = aluNow.carry;
   assign bus.alu_compare   = aluNow.compare;

   function automatic int expectGrant(input logic [NUM_REQ-1:0] mask, input int last);
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (mask[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int idx);
      bus.req_a[16*idx +: 16]     = opA[idx];
      bus.req_b[16*idx +: 16]     = opB[idx];
      bus.req_select[4*idx +: 4]  = opSel[idx];
      bus.req_mode[idx]           = opMode[idx];
      bus.req_carry[idx]          = opCin[idx];
      bus.req_use_flag[idx]       = opUse[idx];
      bus.req_valid[idx]          = 1'b1;
   endtask

   task automatic clearRequests();
      bus.req_valid    = '0;
      bus.req_a        = '0;
      bus.req_b        = '0;
      bus.req_select   = '0;
      bus.req_mode     = '0;
      bus.req_carry    = '0;
      bus.req_use_flag = '0;
   endtask

   task automatic setOp(input int idx, input logic [15:0] a, input logic [15:0] b, input logic [3:0] sel,
                        input logic mode, input logic cin, input logic useFlag);
      opA[idx] = a; opB[idx] = b; opSel[idx] = sel;
      opMode[idx] = mode; opCin[idx] = cin; opUse[idx] = useFlag;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      clearRequests();
      bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      lastGrant = NUM_REQ - 1;
      flagModel = '0;
   endtask

   // One transaction from IDLE at a negedge; returns the captured response
   task automatic runTxn(input string tag, input logic [NUM_REQ-1:0] mask, input int holdCycles,
                         input bit holdValid, output logic [15:0] gotData, output logic gotCarry);
      int      g;
      int      waitCnt;
      logic    cinEff;
      aluRes_t exp;
      gotData  = '0;
      gotCarry = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) if (mask[i]) applyStimulus(i);
      g = expectGrant(mask, lastGrant);
      #1;
      waitCnt = 0;
      while ((bus.req_ready == '0) && (waitCnt < 10)) begin
         @(negedge clk); #1;
         waitCnt++;
      end
      checkOutput({tag, " grant"}, 32'(bus.req_ready), 32'(1) << g);
      if (bus.req_ready == '0) begin
         clearRequests();
         return;
      end
`ifdef ALU_SCHED_CARRY_CHAIN_EN
      cinEff = opUse[g] ? flagModel[g] : opCin[g];
`else
      cinEff = opCin[g];
`endif
      exp = aluModel(opA[g], opB[g], opSel[g], opMode[g], cinEff);
      @(negedge clk);
      clearRequests();
      checkOutput({tag, " exec rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      checkOutput({tag, " alu_in_a"}, 32'(bus.alu_in_a), 32'(opA[g]));
      checkOutput({tag, " alu_carry_in"}, 32'(bus.alu_carry_in), 32'(cinEff));
      @(negedge clk);
      checkOutput({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      checkOutput({tag, " rsp_id"}, 32'(bus.rsp_id), 32'(g));
      checkOutput({tag, " rsp_data"}, 32'(bus.rsp_data), 32'(exp.data));
      checkOutput({tag, " rsp_carry"}, 32'(bus.rsp_carry), 32'(exp.carry));
      checkOutput({tag, " rsp_compare"}, 32'(bus.rsp_compare), 32'(exp.compare));
      checkOutput({tag, " alu hold"}, 32'(bus.alu_in_b), 32'(opB[g]));
      gotData  = bus.rsp_data;
      gotCarry = bus.rsp_carry;
      if (holdValid) bus.req_valid = '1;
      for (int h = 0; h < holdCycles; h++) begin
         @(negedge clk);
         checkOutput({tag, " hold rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
         checkOutput({tag, " hold rsp_data"}, 32'(bus.rsp_data), 32'(exp.data));
         checkOutput({tag, " hold rsp_id"}, 32'(bus.rsp_id), 32'(g));
         checkOutput({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      clearRequests();
      bus.rsp_ready = 1'b0;
      checkOutput({tag, " rsp_valid drop"}, 32'(bus.rsp_valid), 32'd0);
      lastGrant = g;
`ifdef ALU_SCHED_CARRY_CHAIN_EN
      if (opMode[g] == MODE_ARITH) flagModel[g] = exp.carry;
`endif
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t        vecs[6];
      logic [15:0] gotData;
      logic        gotCarry;
      logic [15:0] chainExp;
      int          k;
      int          lastCycle;

      vecs[0] = '{0, 16'h00FF, 16'h0F0F, SEL_XOR, MODE_LOGIC, 1'b0, 16'h0FF0, 1'b0, 1'b0};
      vecs[1] = '{2, 16'hFFFF, 16'h0001, SEL_ADD, MODE_ARITH, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{1, 16'h0005, 16'h0003, SEL_SUB, MODE_ARITH, 1'b1, 16'h0002, 1'b1, 1'b0};
      vecs[3] = '{3, 16'hF0F0, 16'h3C3C, SEL_AND, MODE_LOGIC, 1'b0, 16'h3030, 1'b0, 1'b0};
      vecs[4] = '{0, 16'h1234, 16'h1234, SEL_XOR, MODE_LOGIC, 1'b0, 16'h0000, 1'b0, 1'b1};
      vecs[5] = '{3, 16'h7FFF, 16'h0000, SEL_ADD, MODE_ARITH, 1'b1, 16'h8000, 1'b0, 1'b0};

      for (int i = 0; i < NUM_REQ; i++) setOp(i, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      clearRequests();
      bus.rsp_ready = 1'b0;
      bus.req_valid = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("reset rsp_data", 32'(bus.rsp_data), 32'd0);
      checkOutput("reset rsp_id", 32'(bus.rsp_id), 32'd0);
      checkOutput("reset alu_in_a", 32'(bus.alu_in_a), 32'd0);
      doReset();

      for (int v = 0; v < 6; v++) begin
         setOp(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].sel, vecs[v].mode, vecs[v].cin, 1'b0);
         runTxn($sformatf("vec%0d", v), 4'(1 << vecs[v].idx), 0, 1'b0, gotData, gotCarry);
         checkOutput($sformatf("vec%0d table data", v), 32'(gotData), 32'(vecs[v].expData));
         checkOutput($sformatf("vec%0d table carry", v), 32'(gotCarry), 32'(vecs[v].expCarry));
      end

      setOp(1, 16'hFFFF, 16'h0001, SEL_ADD, MODE_ARITH, 1'b0, 1'b0);
      runTxn("chain0", 4'b0010, 0, 1'b0, gotData, gotCarry);
      setOp(1, 16'h0000, 16'h0000, SEL_ADD, MODE_ARITH, 1'b0, 1'b1);
      runTxn("chain1", 4'b0010, 0, 1'b0, gotData, gotCarry);
`ifdef ALU_SCHED_CARRY_CHAIN_EN
      chainExp = 16'h0001;
`else
      chainExp = 16'h0000;
`endif
      checkOutput("chain second data", 32'(gotData), 32'(chainExp));

      // Round-robin with every requester asserting and the consumer always ready
      doReset();
      for (int i = 0; i < NUM_REQ; i++) begin
         setOp(i, 16'($urandom), 16'($urandom), SEL_XOR, MODE_LOGIC, 1'b0, 1'b0);
         applyStimulus(i);
      end
      bus.rsp_ready = 1'b1;
      k = 0;
      lastCycle = 0;
      for (int cyc = 0; (cyc < 60) && (k < 6); cyc++) begin
         #1;
         if (bus.req_ready != '0) begin
            checkOutput($sformatf("rr grant%0d", k), 32'(bus.req_ready), 32'(1) << (k % NUM_REQ));
            if (k > 0) checkOutput("rr spacing", 32'(cyc - lastCycle), 32'd3);
            lastCycle = cyc;
            k++;
         end
         if (bus.rsp_valid && (k > 0)) begin
            checkOutput("rr rsp_id", 32'(bus.rsp_id), 32'((k - 1) % NUM_REQ));
         end
         @(negedge clk);
      end
      checkOutput("rr grant count", 32'(k), 32'd6);
      clearRequests();
      repeat (3) @(negedge clk);
      bus.rsp_ready = 1'b0;
      lastGrant = 1;

      setOp(3, 16'hABCD, 16'h1111, SEL_OR, MODE_LOGIC, 1'b0, 1'b0);
      runTxn("backpressure", 4'b1000, 5, 1'b1, gotData, gotCarry);
      checkOutput("backpressure data", 32'(gotData), 32'h0000BBDD);

      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            setOp(i, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         runTxn($sformatf("rand%0d", t), 4'($urandom_range(1, 15)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), gotData, gotCarry);
      end

      // Reset while an op sits in EXEC: it must vanish and priority return to requester 0
      setOp(2, 16'h1234, 16'h4321, SEL_ADD, MODE_ARITH, 1'b0, 1'b0);
      applyStimulus(2);
      #1;
      checkOutput("midreset grant", 32'(bus.req_ready), 32'(1) << expectGrant(4'b0100, lastGrant));
      @(negedge clk);
      clearRequests();
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midreset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("midreset rsp_data", 32'(bus.rsp_data), 32'd0);
      checkOutput("midreset alu_in_a", 32'(bus.alu_in_a), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) applyStimulus(i);
      #1;
      checkOutput("midreset next grant", 32'(bus.req_ready), 32'd1);
      clearRequests();
      @(negedge clk);
      checkOutput("midreset idle rsp_valid", 32'(bus.rsp_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
